// File: rtl/keypad_pkg.sv
// Shared types and digit mapping for the parametrised keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  localparam logic [3:0] DIGIT_STAR = 4'hA;
  localparam logic [3:0] DIGIT_HASH = 4'hB;
  localparam logic [3:0] DIGIT_NONE = 4'hF;

  // Row-major 3x4 layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic logic [3:0] code_to_digit(input logic [7:0] code);
    if (code < 8'd9) return 4'(code + 8'd1);
    else if (code == 8'd9) return DIGIT_STAR;
    else if (code == 8'd10) return 4'd0;
    else if (code == 8'd11) return DIGIT_HASH;
    return DIGIT_NONE;
  endfunction

endpackage

// File: rtl/keypad_scanner_param_if.sv
// Keypad matrix lines plus the key event outputs towards number-entry logic.
interface keypad_scanner_param_if #(
  parameter int NUM_COLS = 3,
  parameter int NUM_ROWS = 4,
  parameter int CODE_W   = $clog2(NUM_COLS * NUM_ROWS)
);
  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_out;
  logic                key_valid;
  logic                key_release;
  logic [CODE_W-1:0]   key_code;
  logic [3:0]          key_digit;
  logic                key_down;
  logic                key_multi;

  modport master (
    input  row_in,
    output col_out, key_valid, key_release, key_code, key_digit, key_down, key_multi
  );

  modport slave (
    output row_in,
    input  col_out, key_valid, key_release, key_code, key_digit, key_down, key_multi
  );
endinterface

// File: rtl/keypad_stable_counter.sv
// Counts consecutive clocks where data equals ref_val; done pulses on the
// limit-th matching clock, after which the count restarts from zero.
module keypad_stable_counter #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] ref_val,
  input  logic [CNT_W-1:0]  limit,
  output logic              done
);
  logic [CNT_W-1:0] count;
  logic             match;

  assign match = !clear && (data == ref_val);
  assign done  = match && (count == limit - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (!match || done) count <= '0;
    else count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/keypad_scanner_param.sv
// Column-scanning keypad controller: press/release debounce, multi-key
// rejection, optional auto-repeat and 3x4 digit mapping.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int NUM_COLS        = 3,
  parameter int NUM_ROWS        = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CODE_W          = $clog2(NUM_COLS * NUM_ROWS)
) (
  input logic                    clk,
  input logic                    rst_n,
  keypad_scanner_param_if.master bus
);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 2);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit IS_3X4 = (NUM_COLS == 3) && (NUM_ROWS == 4);
  localparam logic [NUM_ROWS-1:0] IDLE = '1;
  // The synchroniser adds two clocks before a new column's rows are visible,
  // so settling is counted on top of that latency.
  localparam logic [SET_W-1:0] SAMPLE_AT = SET_W'(SETTLE_CYCLES + 1);

  logic [1:0]          rst_sync;
  logic                rst_int_n;
  logic [NUM_ROWS-1:0] row_meta, rows, pattern;
  scan_state_e         state;
  logic [COL_W-1:0]    col_idx, col_next;
  logic [SET_W-1:0]    settle_cnt;
  logic [CODE_W-1:0]   code_q, new_code;
  logic [3:0]          digit_q;
  logic                valid_q, release_q, multi_q, down_q;
  logic                press_done, rel_done, rep_done, single_key;
  int                  zero_cnt, row_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      row_meta <= '1;
      rows     <= '1;
    end else begin
      row_meta <= bus.row_in;
      rows     <= row_meta;
    end
  end

  always_comb begin
    zero_cnt = 0;
    row_idx  = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!pattern[r]) begin
        zero_cnt = zero_cnt + 1;
        row_idx  = r;
      end
    end
  end

  assign single_key = (zero_cnt == 1);
  assign new_code   = CODE_W'(row_idx * NUM_COLS + int'(col_idx));
  assign col_next   = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + COL_W'(1);

  keypad_stable_counter #(.DATA_W(NUM_ROWS), .CNT_W(DEB_W)) u_press (
    .clk(clk), .rst_n(rst_int_n), .clear(state != DEBOUNCE),
    .data(rows), .ref_val(pattern), .limit(DEB_W'(DEBOUNCE_CYCLES)), .done(press_done)
  );

  keypad_stable_counter #(.DATA_W(NUM_ROWS), .CNT_W(DEB_W)) u_release (
    .clk(clk), .rst_n(rst_int_n), .clear(state != HELD),
    .data(rows), .ref_val(IDLE), .limit(DEB_W'(DEBOUNCE_CYCLES)), .done(rel_done)
  );

  generate
    if (REPEAT_EN != 0 && REPEAT_DELAY > 0 && REPEAT_RATE > 0) begin : g_repeat
      localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int REP_W   = $clog2(REP_MAX + 1);
      logic rep_first, rep_clear;

      assign rep_clear = !((state == HELD) && down_q);

      always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) rep_first <= 1'b1;
        else if (rep_clear) rep_first <= 1'b1;
        else if (rep_done) rep_first <= 1'b0;
      end

      keypad_stable_counter #(.DATA_W(1), .CNT_W(REP_W)) u_repeat (
        .clk(clk), .rst_n(rst_int_n), .clear(rep_clear),
        .data(1'b0), .ref_val(1'b0),
        .limit(rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE)),
        .done(rep_done)
      );
    end else begin : g_no_repeat
      assign rep_done = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= SCAN;
      col_idx    <= '0;
      settle_cnt <= '0;
      pattern    <= '1;
      code_q     <= '0;
      digit_q    <= DIGIT_NONE;
      valid_q    <= 1'b0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
      case (state)
        SCAN: begin
          if (settle_cnt == SAMPLE_AT) begin
            settle_cnt <= '0;
            if (rows == IDLE) begin
              col_idx <= col_next;
            end else begin
              pattern <= rows;
              state   <= DEBOUNCE;
            end
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        DEBOUNCE: begin
          if (rows != pattern) begin
            state <= SCAN;
          end else if (press_done) begin
            state <= HELD;
            if (single_key) begin
              code_q  <= new_code;
              digit_q <= IS_3X4 ? code_to_digit(8'(new_code)) : DIGIT_NONE;
              valid_q <= 1'b1;
              down_q  <= 1'b1;
            end else begin
              multi_q <= 1'b1;
            end
          end
        end
        HELD: begin
          // Release wins over a coincident repeat so pulses never overlap.
          if (rel_done) begin
            release_q <= down_q;
            down_q    <= 1'b0;
            col_idx   <= col_next;
            state     <= SCAN;
          end else if (rep_done) begin
            valid_q <= 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.col_out     = ~(NUM_COLS'(1) << col_idx);
  assign bus.key_valid   = valid_q;
  assign bus.key_release = release_q;
  assign bus.key_multi   = multi_q;
  assign bus.key_code    = code_q;
  assign bus.key_digit   = digit_q;
  assign bus.key_down    = down_q;
endmodule
